// File: rtl/dram_responder_pkg.sv
// Shared types and constants for the data-memory SRAM responder.
package dram_responder_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic       STROBE_OFF = 1'b1;
  localparam logic [3:0] BE_NONE    = 4'hF;

endpackage

// File: rtl/dram_responder.sv
// Single-outstanding load/store responder driving an asynchronous SRAM with
// active-low strobes and a fixed number of strobe-active wait cycles.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [3:0]        cpu_sel_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  localparam int unsigned CntW = $clog2(16);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [3:0]        be_n_q;
  logic              we_q;

  logic unused_addr;
  assign unused_addr = ^{cpu_addr_i[31:ADDR_W+2], cpu_addr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_n_q  <= BE_NONE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Request is captured once; cpu_* changes during the access are ignored.
      if (state_q == StIdle && cpu_ce_i) begin
        addr_q  <= cpu_addr_i[ADDR_W+1:2];
        wdata_q <= cpu_data_i;
        be_n_q  <= ~cpu_sel_i;
        we_q    <= cpu_we_i;
      end
      if (state_q == StAccess && cnt_q == '0 && !we_q) begin
        rdata_q <= sram_rdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_ce_i) begin
          cnt_d   = CntW'(WAIT_CYCLES - 1);
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sram_ce_n_o = STROBE_OFF;
    sram_oe_n_o = STROBE_OFF;
    sram_we_n_o = STROBE_OFF;
    sram_be_n_o = BE_NONE;
    if (state_q == StAccess) begin
      sram_ce_n_o = 1'b0;
      sram_oe_n_o = we_q;
      sram_we_n_o = ~we_q;
      sram_be_n_o = be_n_q;
    end else if (state_q == StDone) begin
      // Byte enables held one cycle past the we_n rising edge for write hold.
      sram_be_n_o = be_n_q;
    end
  end

  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign cpu_data_o   = rdata_q;
  assign cpu_stall_o  = cpu_ce_i & (state_q != StDone) & ~rst;

endmodule
